// File: rtl/ifetch_pkg.sv
// Shared core package: fetch FSM states, NOP encoding and default reset PC.
// IFETCH_MISALIGN_TRAP_EN adds the FAULT state used by the misaligned-target trap.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } ifetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifetch_state_t;
`endif

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory request/response channel between ifetch (master) and memory (slave).
interface ifetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch unit: request, wait for data, hold for the hart.
// Defining IFETCH_MISALIGN_TRAP_EN adds fetch_fault and traps on misaligned nextpc.
//
// state | meaning
// REQ   | request pc from memory (imem_req=1 once out of reset)
// WAIT  | request accepted, waiting for rvalid
// HOLD  | insn/pc valid, waiting for the hart to advance
// FAULT | misaligned nextpc accepted; parked until reset (trap build only)
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_if.master      imem,
    output logic [31:0]   insn,
    output logic [31:0]   pc,
    output logic          insn_valid,
    input  logic          advance,
    input  logic [31:0]   nextpc
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic          fetch_fault
`endif
);

    ifetch_state_t state, state_next;
    logic          req_q, req_next;
    logic [31:0]   pc_next, insn_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_REQ;
            req_q <= 1'b0;
            pc    <= RESET_PC;
            insn  <= NOP_INSN;
        end else begin
            state <= state_next;
            req_q <= req_next;
            pc    <= pc_next;
            insn  <= insn_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        insn_next  = insn;
        case (state)
            ST_REQ: begin
                if (req_q && imem.ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    insn_next  = imem.rdata;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (advance) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                    pc_next    = nextpc;
                    state_next = is_misaligned(nextpc) ? ST_FAULT : ST_REQ;
`else
                    pc_next    = word_align(nextpc);
                    state_next = ST_REQ;
`endif
                end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            ST_FAULT: state_next = ST_FAULT;
`endif
            default: state_next = ST_REQ;
        endcase
        // Registered so the request stays low for the whole reset and its first cycle out.
        req_next = (state_next == ST_REQ);
    end

    assign imem.req   = req_q;
    assign imem.addr  = pc;
    assign insn_valid = (state == ST_HOLD);

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state == ST_FAULT);
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a transaction-level reference model and per-cycle compare.
// Build with IFETCH_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] insn, pc, nextpc;
    logic        insn_valid, advance;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .imem       (bus),
        .insn       (insn),
        .pc         (pc),
        .insn_valid (insn_valid),
        .advance    (advance),
        .nextpc     (nextpc)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault(fetch_fault)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one request in flight at most; a fetched word is held until the hart takes it.
    logic        m_asked, m_busy, m_held, m_fault;
    logic [31:0] m_pc, m_insn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_asked = 1'b0;
            m_busy  = 1'b0;
            m_held  = 1'b0;
            m_fault = 1'b0;
            m_pc    = RST_PC;
            m_insn  = 32'h0000_0013;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_held) begin
            if (advance) begin
                m_held = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                m_pc = nextpc;
                if (nextpc % 4 != 0) m_fault = 1'b1;
                else                 m_asked = 1'b1;
`else
                m_pc    = nextpc - (nextpc % 4);
                m_asked = 1'b1;
`endif
            end
        end else if (m_busy) begin
            if (bus.rvalid) begin
                m_insn = bus.rdata;
                m_held = 1'b1;
                m_busy = 1'b0;
            end
        end else if (m_asked && bus.ready) begin
            m_busy  = 1'b1;
            m_asked = 1'b0;
        end else begin
            m_asked = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("m_imem_req", bus.req, m_asked);
        chk("m_insn_valid", insn_valid, m_held);
        chk("m_pc", pc, m_pc);
        chk("m_insn", insn, m_insn);
        if (m_asked) chk("m_imem_addr", bus.addr, m_pc);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("m_fetch_fault", fetch_fault, m_fault);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.ready  = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        advance    = 1'b0;
        nextpc     = 32'h0;
        #1 rst_n = 1'b0;
        step(2);
        chk("rst_insn", insn, 32'h0000_0013);
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", bus.req, 0);
        chk("rst_valid", insn_valid, 0);

        // First fetch after reset, zero-wait memory
        rst_n = 1'b1;
        bus.ready = 1'b1;
        step(1);
        chk("first_req", bus.req, 1);
        chk("first_addr", bus.addr, 32'h0);
        step(1);
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0050_0093;
        step(1);
        bus.rvalid = 1'b0;
        chk("first_valid", insn_valid, 1);
        chk("first_insn", insn, 32'h0050_0093);
        chk("first_pc", pc, 32'h0);

        // Turnaround with top-of-memory target used verbatim
        advance = 1'b1; nextpc = 32'hFFFF_FFFC;
        step(1);
        advance = 1'b0;
        chk("turn_req", bus.req, 1);
        chk("turn_addr", bus.addr, 32'hFFFF_FFFC);
        chk("turn_valid", insn_valid, 0);
        bus.ready = 1'b1;
        step(1);
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_0113;
        step(1);
        bus.rvalid = 1'b0;
        chk("turn_valid3", insn_valid, 1);
        chk("turn_insn", insn, 32'h0000_0113);

        // Redirect to 0x100
        advance = 1'b1; nextpc = 32'h0000_0100;
        step(1);
        advance = 1'b0;
        chk("redir_req", bus.req, 1);
        chk("redir_addr", bus.addr, 32'h100);
        chk("redir_valid", insn_valid, 0);

        // advance while nothing is held must not move pc
        advance = 1'b1; nextpc = 32'h0000_0300;
        step(1);
        advance = 1'b0;
        chk("adv_req_pc", pc, 32'h100);

        // Memory stalls the request
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_req", bus.req, 1);
            chk("stall_addr", bus.addr, 32'h100);
        end

        // rvalid coincident with accept is ignored
        bus.ready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_DEAD;
        step(1);
        bus.ready = 1'b0; bus.rvalid = 1'b0;
        chk("acc_rvalid_valid", insn_valid, 0);
        chk("acc_rvalid_req", bus.req, 0);

        // advance during WAIT is ignored
        advance = 1'b1; nextpc = 32'h0000_0200;
        step(1);
        advance = 1'b0;
        step(1);
        chk("wait_valid", insn_valid, 0);
        bus.rvalid = 1'b1; bus.rdata = 32'h0000_0513;
        step(1);
        bus.rvalid = 1'b0;
        chk("wait_adv_pc", pc, 32'h100);
        chk("wait_adv_insn", insn, 32'h0000_0513);
        chk("wait_adv_valid", insn_valid, 1);

        // insn keeps its value after leaving HOLD
        advance = 1'b1; nextpc = 32'h0000_0104;
        step(1);
        advance = 1'b0;
        chk("keep_insn", insn, 32'h0000_0513);
        chk("keep_valid", insn_valid, 0);
        bus.ready = 1'b1;
        step(1);
        bus.ready = 1'b0;

        // Reset while waiting, with a response arriving during and just after reset
        rst_n = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        step(1);
        chk("midrst_insn", insn, 32'h0000_0013);
        chk("midrst_valid", insn_valid, 0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_req", bus.req, 0);
        rst_n = 1'b1;
        step(1);
        bus.rvalid = 1'b0;
        chk("late_rvalid_valid", insn_valid, 0);
        chk("late_rvalid_insn", insn, 32'h0000_0013);
        chk("late_rvalid_req", bus.req, 1);
        bus.ready = 1'b1;
        step(1);
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h00A0_0593;
        step(1);
        bus.rvalid = 1'b0;
        chk("refetch_insn", insn, 32'h00A0_0593);
        chk("refetch_pc", pc, RST_PC);

        // Misaligned target
        advance = 1'b1; nextpc = 32'h0000_0102;
        step(1);
        advance = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("mis_fault", fetch_fault, 1);
        chk("mis_req", bus.req, 0);
        chk("mis_valid", insn_valid, 0);
        chk("mis_pc", pc, 32'h0000_0102);
        bus.ready = 1'b1; bus.rvalid = 1'b1;
        step(3);
        bus.ready = 1'b0; bus.rvalid = 1'b0;
        chk("mis_fault_hold", fetch_fault, 1);
        chk("mis_pc_hold", pc, 32'h0000_0102);
`else
        chk("mis_req", bus.req, 1);
        chk("mis_addr", bus.addr, 32'h0000_0100);
        chk("mis_pc", pc, 32'h0000_0100);
`endif
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
